uart_bus_master: RTL and testbench

Serial debug bridge: receives command frames on a UART line, takes the Z80 bus via the CPU's bus-request handshake, performs one memory or I/O read/write, and replies over UART. It is the bus-initiator counterpart to the UART I/O responder: it drives the same address/strobe bus the CPU drives. Intended for loading and inspecting memory in the mini-computer without CPU software.

---
 rtl/z80_mini_pkg.sv | 35 +++
 rtl/bridge_uart_rx.sv | 93 +++++++++
 rtl/uart_bus_master.sv | 189 ++++++++++++++++++
 tb/tb_uart_bus_master.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_mini_pkg.sv
// Shared definitions for the z80_mini debug bridge: command opcodes,
// response codes and the bridge FSM state encoding.
package z80_mini_pkg;

    localparam logic [7:0] CMD_MEM_WR = 8'h57;
    localparam logic [7:0] CMD_MEM_RD = 8'h52;
    localparam logic [7:0] CMD_IO_WR  = 8'h4F;
    localparam logic [7:0] CMD_IO_RD  = 8'h49;

    localparam logic [7:0] RSP_WR_OK   = 8'h2E;
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_AH,
        ST_GET_AL,
        ST_GET_D,
        ST_REQ,
        ST_ACCESS,
        ST_RESP
    } bridge_state_t;

    function automatic logic is_known_cmd(input logic [7:0] cmd);
        return cmd inside {CMD_MEM_WR, CMD_MEM_RD, CMD_IO_WR, CMD_IO_RD};
    endfunction

    function automatic logic is_write_cmd(input logic [7:0] cmd);
        return (cmd == CMD_MEM_WR) || (cmd == CMD_IO_WR);
    endfunction

    function automatic logic is_io_cmd(input logic [7:0] cmd);
        return (cmd == CMD_IO_WR) || (cmd == CMD_IO_RD);
    endfunction

endpackage

// File: rtl/bridge_uart_rx.sv
// UART receiver for the debug bridge: 8N1, CLK_DIV clocks per bit.
// Frames with a low stop bit are discarded silently.
module bridge_uart_rx #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state;
    logic             rxd_meta, rxd_sync, rxd_prev;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // NOTE: sequential state is written with <= only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_state <= RX_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rxd_prev && !rxd_sync) begin
                        rx_state <= RX_START;
                        tick_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (tick_cnt == HALF_LAST) begin
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        // A start bit that is high again by mid-bit was a glitch.
                        rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_cnt <= '0;
                        shift    <= {rxd_sync, shift[7:1]};
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                        else                 bit_idx  <= bit_idx + 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_cnt <= '0;
                        rx_state <= RX_IDLE;
                        if (rxd_sync) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= shift;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// UART-to-Z80-bus debug bridge: decodes command frames, takes the bus via
// bus_req/bus_ack, performs one access and replies. Define
// UART_BUS_MASTER_TIMEOUT_EN to abandon partial frames after TIMEOUT clocks.
module uart_bus_master
    import z80_mini_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int ACC_CYCLES = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        rxd,
    output logic        txd,
    output logic        bus_req,
    input  logic        bus_ack,
    output logic [15:0] addr,
    output logic [7:0]  data_out,
    input  logic [7:0]  data_in,
    output logic        mreq,
    output logic        iorq,
    output logic        rd,
    output logic        wr,
    output logic        busy,
    output logic        rx_drop
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int ACC_W = $clog2(ACC_CYCLES + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACC_CYCLES - 1);

    logic             rx_valid;
    logic [7:0]       rx_byte;

    bridge_state_t    state;
    logic [7:0]       cmd;
    logic [15:0]      addr_q;
    logic [7:0]       wdata_q;
    logic [ACC_W-1:0] acc_cnt;
    logic [9:0]       tx_frame;
    logic             tx_first;
    logic [3:0]       tx_idx;
    logic [CNT_W-1:0] tx_cnt;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]  to_cnt;
`endif

    bridge_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk      (clk),
        .n_rst    (n_rst),
        .rxd      (rxd),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            cmd      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            acc_cnt  <= '0;
            tx_frame <= '1;
            tx_first <= 1'b0;
            tx_idx   <= '0;
            tx_cnt   <= '0;
            txd      <= 1'b1;
            bus_req  <= 1'b0;
            addr     <= '0;
            data_out <= '0;
            mreq     <= 1'b0;
            iorq     <= 1'b0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            busy     <= 1'b0;
            rx_drop  <= 1'b0;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            rx_drop <= rx_valid && (state inside {ST_REQ, ST_ACCESS, ST_RESP});
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        busy <= 1'b1;
                        if (is_known_cmd(rx_byte)) begin
                            cmd     <= rx_byte;
                            wdata_q <= '0;
                            state   <= ST_GET_AH;
                        end else begin
                            tx_frame <= {1'b1, RSP_UNKNOWN, 1'b0};
                            tx_first <= 1'b1;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_GET_AH: begin
                    if (rx_valid) begin
                        addr_q[15:8] <= rx_byte;
                        state        <= ST_GET_AL;
                    end
                end
                ST_GET_AL: begin
                    if (rx_valid) begin
                        addr_q[7:0] <= rx_byte;
                        if (is_write_cmd(cmd)) begin
                            state <= ST_GET_D;
                        end else begin
                            bus_req <= 1'b1;
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_GET_D: begin
                    if (rx_valid) begin
                        wdata_q <= rx_byte;
                        bus_req <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        addr     <= addr_q;
                        data_out <= wdata_q;
                        mreq     <= !is_io_cmd(cmd);
                        iorq     <= is_io_cmd(cmd);
                        wr       <= is_write_cmd(cmd);
                        rd       <= !is_write_cmd(cmd);
                        acc_cnt  <= '0;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // bus_ack is not re-checked: once granted, the access runs to completion.
                    if (acc_cnt == ACC_LAST) begin
                        mreq     <= 1'b0;
                        iorq     <= 1'b0;
                        rd       <= 1'b0;
                        wr       <= 1'b0;
                        bus_req  <= 1'b0;
                        tx_frame <= {1'b1, (is_write_cmd(cmd) ? RSP_WR_OK : data_in), 1'b0};
                        tx_first <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (tx_first) begin
                        txd      <= tx_frame[0];
                        tx_frame <= {1'b1, tx_frame[9:1]};
                        tx_first <= 1'b0;
                        tx_idx   <= '0;
                        tx_cnt   <= '0;
                    end else if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 4'd9) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            txd      <= tx_frame[0];
                            tx_frame <= {1'b1, tx_frame[9:1]};
                            tx_idx   <= tx_idx + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef UART_BUS_MASTER_TIMEOUT_EN
            // Placed after the case so the abort overrides a same-cycle state update.
            if (rx_valid || !(state inside {ST_GET_AH, ST_GET_AL, ST_GET_D})) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                to_cnt <= '0;
                busy   <= 1'b0;
                state  <= ST_IDLE;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: directed command frames, with bus
// accesses and UART replies checked by independent monitors.
module tb_uart_bus_master;

    localparam int CLK_DIV    = 8;
    localparam int ACC_CYCLES = 4;
    localparam int TIMEOUT    = 200;

    typedef struct packed {
        logic        io;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_txn_t;

    logic        clk, n_rst, rxd, txd;
    logic        bus_req, bus_ack, mreq, iorq, rd, wr, busy, rx_drop;
    logic [15:0] addr;
    logic [7:0]  data_out, data_in;
    logic [2:0]  ack_pipe;
    logic        bus_req_d = 1'b0;

    int checks   = 0;
    int errors   = 0;
    int drop_cnt = 0;
    int req_cnt  = 0;

    bus_txn_t   exp_bus[$];
    logic [7:0] exp_tx[$];

    uart_bus_master #(
        .CLK_DIV    (CLK_DIV),
        .ACC_CYCLES (ACC_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rxd      (rxd),
        .txd      (txd),
        .bus_req  (bus_req),
        .bus_ack  (bus_ack),
        .addr     (addr),
        .data_out (data_out),
        .data_in  (data_in),
        .mreq     (mreq),
        .iorq     (iorq),
        .rd       (rd),
        .wr       (wr),
        .busy     (busy),
        .rx_drop  (rx_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CPU model: grants the bus three clocks after the request.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) ack_pipe <= '0;
        else        ack_pipe <= {ack_pipe[1:0], bus_req};
    end
    assign bus_ack = ack_pipe[2];

    always @(negedge clk) begin
        if (rx_drop) drop_cnt++;
        if (bus_req && !bus_req_d) req_cnt++;
        bus_req_d = bus_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic expect_bus(input logic io, input logic w, input logic [15:0] a, input logic [7:0] d);
        bus_txn_t t;
        t.io   = io;
        t.wr   = w;
        t.addr = a;
        t.data = d;
        exp_bus.push_back(t);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_tx.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completes"}, n < 3000, 1);
        repeat (4) @(negedge clk);
    endtask

    // Bus monitor: one record per strobe burst, compared against exp_bus.
    initial begin : bus_monitor
        bus_txn_t cur, e;
        int       len;
        logic     bad;
        forever begin
            @(negedge clk);
            if (n_rst && (mreq || iorq)) begin
                cur = {iorq, wr, addr, data_out};
                len = 0;
                bad = 1'b0;
                while ((mreq || iorq) && len < 100) begin
                    len++;
                    if (mreq == iorq || rd == wr || !bus_req ||
                        {iorq, wr, addr, data_out} != cur) bad = 1'b1;
                    @(negedge clk);
                end
                check("strobe_length", len, ACC_CYCLES);
                check("strobe_shape", bad, 0);
                check("bus_req_drops_with_strobes", bus_req, 0);
                if (exp_bus.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got access at 0x%04h, expected none", cur.addr);
                end else begin
                    e = exp_bus.pop_front();
                    check("bus_is_io", cur.io, e.io);
                    check("bus_is_write", cur.wr, e.wr);
                    check("bus_addr", cur.addr, e.addr);
                    if (e.wr) check("bus_data_out", cur.data, e.data);
                end
            end
        end
    end

    // UART reply monitor: decodes txd and compares against exp_tx.
    initial begin : tx_monitor
        logic [7:0] b;
        logic       stop;
        forever begin
            @(negedge clk);
            if (n_rst && txd == 1'b0) begin
                repeat (CLK_DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CLK_DIV) @(negedge clk);
                stop = txd;
                check("tx_stop_bit", stop, 1);
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte 0x%02h, expected none", b);
                end else begin
                    check("tx_byte", b, exp_tx.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int r0, d0;
        rxd     = 1'b1;
        n_rst   = 1'b0;
        data_in = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_bus_req", bus_req, 0);
        check("rst_strobes", {mreq, iorq, rd, wr}, 4'b0000);
        check("rst_busy", busy, 0);
        check("rst_rx_drop", rx_drop, 0);
        check("rst_addr", addr, 16'h0000);
        check("rst_data_out", data_out, 8'h00);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_txd", txd, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_bus_req", bus_req, 0);

        // Memory write
        expect_bus(1'b0, 1'b1, 16'h1234, 8'hAB);
        exp_tx.push_back(8'h2E);
        send_byte(8'h57, 1'b1);
        check("busy_after_cmd", busy, 1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        wait_idle("mem_write");

        // Memory read
        data_in = 8'h5A;
        expect_bus(1'b0, 1'b0, 16'h0010, 8'h00);
        exp_tx.push_back(8'h5A);
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        wait_idle("mem_read");

        // I/O write
        expect_bus(1'b1, 1'b1, 16'h0084, 8'h41);
        exp_tx.push_back(8'h2E);
        send_byte(8'h4F, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h84, 1'b1);
        send_byte(8'h41, 1'b1);
        wait_idle("io_write");

        // Unknown command
        r0 = req_cnt;
        exp_tx.push_back(8'h3F);
        send_byte(8'h00, 1'b1);
        wait_idle("unknown_cmd");
        check("unknown_no_bus_req", req_cnt - r0, 0);

        // Framing error: discarded, no drop pulse, FSM stays idle
        r0 = req_cnt;
        d0 = drop_cnt;
        send_byte(8'h57, 1'b0);
        repeat (100) @(negedge clk);
        check("framing_busy", busy, 0);
        check("framing_no_bus_req", req_cnt - r0, 0);
        check("framing_no_rx_drop", drop_cnt - d0, 0);
        data_in = 8'h96;
        expect_bus(1'b0, 1'b0, 16'h0010, 8'h00);
        exp_tx.push_back(8'h96);
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        wait_idle("read_after_framing");

        // Extra byte arriving during RESP is dropped
        d0 = drop_cnt;
        data_in = 8'h3C;
        expect_bus(1'b0, 1'b0, 16'h0010, 8'h00);
        exp_tx.push_back(8'h3C);
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'hA5, 1'b1);
        wait_idle("read_with_extra");
        check("extra_byte_rx_drop", drop_cnt - d0, 1);

`ifdef UART_BUS_MASTER_TIMEOUT_EN
        // Partial frame abandoned after TIMEOUT clocks
        r0 = req_cnt;
        send_byte(8'h57, 1'b1);
        send_byte(8'h12, 1'b1);
        check("timeout_busy_before", busy, 1);
        repeat (300) @(negedge clk);
        check("timeout_busy_after", busy, 0);
        check("timeout_no_bus_req", req_cnt - r0, 0);
        data_in = 8'hC3;
        expect_bus(1'b0, 1'b0, 16'h0010, 8'h00);
        exp_tx.push_back(8'hC3);
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        wait_idle("read_after_timeout");
`endif

        repeat (20) @(negedge clk);
        check("bus_queue_drained", exp_bus.size(), 0);
        check("tx_queue_drained", exp_tx.size(), 0);
        check("final_busy", busy, 0);
        check("final_txd", txd, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
